// File: rtl/sms4_sbox_pkg.sv
// Composite-field GF((2^4)^2) constants and helpers shared by the SMS4 S-box inverter.
// Macro SBOX_INV_STAGE2_EN selects the 3-stage build (latency 3); undefined gives 2 stages.
package sms4_sbox_pkg;

    localparam logic [4:0] GF16_POLY  = 5'b10011;
    localparam logic [3:0] GF8_LAMBDA = 4'hC;

`ifdef SBOX_INV_STAGE2_EN
    localparam int SBOX_INV_LATENCY = 3;
`else
    localparam int SBOX_INV_LATENCY = 2;
`endif

    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] gf16_cmul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) acc = acc ^ ({3'b000, a} << i);
        for (int k = 6; k >= 4; k--)
            if (acc[k]) acc = acc ^ ({2'b00, GF16_POLY} << (k - 4));
        return acc[3:0];
    endfunction

    // Column i is lambda * (x^i)^2, so lambda*h^2 is the XOR of the columns selected by h.
    localparam logic [15:0] LAMBDA_SQ_COLS = {gf16_cmul(GF8_LAMBDA, gf16_sq(4'h8)),
                                              gf16_cmul(GF8_LAMBDA, gf16_sq(4'h4)),
                                              gf16_cmul(GF8_LAMBDA, gf16_sq(4'h2)),
                                              gf16_cmul(GF8_LAMBDA, gf16_sq(4'h1))};

    function automatic logic [3:0] lambda_sq(input logic [3:0] h);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (h[i]) r = r ^ LAMBDA_SQ_COLS[4*i +: 4];
        return r;
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier, reduction polynomial x^4+x+1.
module gf16_mul
    import sms4_sbox_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    assign p = gf16_cmul(a, b);

endmodule

// File: rtl/sbox_inv_pipe.sv
// Pipelined multi-lane GF((2^4)^2) inverter with valid/ready flow control.
// Macro SBOX_INV_STAGE2_EN inserts the S2 register between Delta^-1 and the output multiplies.
module sbox_inv_pipe
    import sms4_sbox_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);

    logic                  vld_p0, vld_p2, vld_m;
    logic                  rdy_p0, rdy_p2;
    logic                  ld_p0, ld_p2;
    logic [LANES-1:0][3:0] h_in, l_in, hl_in, delta_in;
    logic [LANES-1:0][3:0] h_p0, l_p0, delta_p0, d_inv;
    logic [LANES-1:0][3:0] h_m, l_m, d_m, hxl_m, oh, ol;
    logic [8*LANES-1:0]    out_nxt;

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign rdy_p2    = !vld_p2 | out_ready;
    assign ld_p0     = in_valid & rdy_p0;
    assign ld_p2     = vld_m & rdy_p2;
    assign in_ready  = rdy_p0;
    assign out_valid = vld_p2;

`ifdef SBOX_INV_STAGE2_EN
    logic                  vld_p1, rdy_p1, ld_p1;
    logic [LANES-1:0][3:0] h_p1, l_p1, d_p1;

    assign rdy_p1 = !vld_p1 | rdy_p2;
    assign rdy_p0 = !vld_p0 | rdy_p1;
    assign ld_p1  = vld_p0 & rdy_p1;
    assign vld_m  = vld_p1;
    assign h_m    = h_p1;
    assign l_m    = l_p1;
    assign d_m    = d_p1;
`else
    assign rdy_p0 = !vld_p0 | rdy_p2;
    assign vld_m  = vld_p0;
    assign h_m    = h_p0;
    assign l_m    = l_p0;
    assign d_m    = d_inv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
`ifdef SBOX_INV_STAGE2_EN
            vld_p1 <= 1'b0;
`endif
            vld_p2 <= 1'b0;
        end else begin
            if (rdy_p0) vld_p0 <= in_valid;
`ifdef SBOX_INV_STAGE2_EN
            if (rdy_p1) vld_p1 <= vld_p0;
            if (rdy_p2) vld_p2 <= vld_p1;
`else
            if (rdy_p2) vld_p2 <= vld_p0;
`endif
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign h_in[i]     = in_data[8*i+4 +: 4];
        assign l_in[i]     = in_data[8*i   +: 4];
        assign delta_in[i] = lambda_sq(h_in[i]) ^ hl_in[i] ^ gf16_sq(l_in[i]);
        assign hxl_m[i]    = h_m[i] ^ l_m[i];
        assign out_nxt[8*i +: 8] = {oh[i], ol[i]};

        gf16_mul u_mul_hl (.a(h_in[i]),  .b(l_in[i]), .p(hl_in[i]));
        gf16_mul u_mul_oh (.a(h_m[i]),   .b(d_m[i]),  .p(oh[i]));
        gf16_mul u_mul_ol (.a(hxl_m[i]), .b(d_m[i]),  .p(ol[i]));
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) d_inv[i] = gf16_inv(delta_p0[i]);
    end

    // S1: h, l, Delta
    always_ff @(posedge clk) begin
        if (ld_p0) begin
            h_p0     <= h_in;
            l_p0     <= l_in;
            delta_p0 <= delta_in;
        end
    end

`ifdef SBOX_INV_STAGE2_EN
    // S2: h, l, Delta^-1
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            h_p1 <= h_p0;
            l_p1 <= l_p0;
            d_p1 <= d_inv;
        end
    end
`endif

    // S3: inverted bytes, cleared by reset so a flushed pipe presents zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     out_data <= '0;
        else if (ld_p2) out_data <= out_nxt;
    end

endmodule
